// File: rtl/bias_relu_stage.sv
// Bias-add, fixed-point rescale, ReLU and saturation for one layer's accumulated sums.
// Captures a whole vector, processes one neuron per cycle, then holds the result under valid/ready.
module bias_relu_stage #(
  parameter int dataWidth     = 16,
  parameter int NsInNextLayer = 30,
  parameter int accWidth      = 42,
  parameter int fracBits      = 8
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           in_valid,
  output logic                                           in_ready,
  input  logic signed [NsInNextLayer-1:0][accWidth-1:0]  inputSums,
  input  logic signed [NsInNextLayer-1:0][dataWidth-1:0] biases,
  output logic                                           out_valid,
  input  logic                                           out_ready,
  output logic signed [NsInNextLayer-1:0][dataWidth-1:0] outputActivation,
  output logic [1:0]                                     dbg_state_o
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both 1.
  // in_ready is only high in IDLE, out_valid only in DONE, so accept and deliver never overlap.

  localparam int IDX_W = (NsInNextLayer > 1) ? $clog2(NsInNextLayer) : 1;
  localparam logic signed [accWidth:0] ACT_MAX = (accWidth+1)'((64'd1 << (dataWidth-1)) - 64'd1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PROC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                                 state_q;
  logic [IDX_W-1:0]                       idx_q;
  logic [NsInNextLayer-1:0][accWidth-1:0]  sum_q;
  logic [NsInNextLayer-1:0][dataWidth-1:0] bias_q;
  logic [NsInNextLayer-1:0][dataWidth-1:0] act_q;
  logic                                   in_ready_q;
  logic                                   out_valid_q;

  logic signed [accWidth-1:0]  sum_sel;
  logic signed [accWidth-1:0]  sum_shr;
  logic signed [dataWidth-1:0] bias_sel;
  logic signed [accWidth:0]    v_d;
  logic [dataWidth-1:0]        act_d;

  // One extra bit of headroom so the bias add cannot wrap before clamping.
  always_comb begin
    sum_sel  = sum_q[idx_q];
    bias_sel = bias_q[idx_q];
    sum_shr  = sum_sel >>> fracBits;
    v_d      = {sum_shr[accWidth-1], sum_shr}
             + {{(accWidth+1-dataWidth){bias_sel[dataWidth-1]}}, bias_sel};
    act_d    = v_d[dataWidth-1:0];
    if (v_d[accWidth]) begin
      act_d = '0;
    end else if (v_d > ACT_MAX) begin
      act_d = ACT_MAX[dataWidth-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      sum_q       <= '0;
      bias_q      <= '0;
      act_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          if (in_valid && in_ready_q) begin
            sum_q      <= inputSums;
            bias_q     <= biases;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= PROC;
          end
        end
        PROC: begin
          in_ready_q    <= 1'b0;
          act_q[idx_q]  <= act_d;
          idx_q         <= idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(NsInNextLayer-1)) begin
            idx_q       <= '0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          in_ready_q <= 1'b0;
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Gate with reset so in_ready reads 0 for the whole time rst is held low.
  assign in_ready         = in_ready_q & rst;
  assign out_valid        = out_valid_q;
  assign outputActivation = act_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_bias_relu_stage.sv
// Directed sequence with randomized vectors for bias_relu_stage, checked against an
// arithmetic reference model and an expected-value queue.
module tb_bias_relu_stage;

  localparam int DW   = 16;
  localparam int N    = 30;
  localparam int ACC  = 42;
  localparam int FRAC = 8;

  logic                  clk;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  logic [N-1:0][ACC-1:0] sums_drv;
  logic [N-1:0][DW-1:0]  bias_drv;
  logic                  out_valid;
  logic                  out_ready;
  logic [N-1:0][DW-1:0]  out_act;
  logic [1:0]            dbg_state;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  longint         vs[N];
  int             vb[N];
  logic [DW-1:0]  last_exp[N];
  logic [DW-1:0]  exp_q[$];

  bias_relu_stage #(
    .dataWidth(DW), .NsInNextLayer(N), .accWidth(ACC), .fracBits(FRAC)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .inputSums(sums_drv), .biases(bias_drv), .out_valid(out_valid),
    .out_ready(out_ready), .outputActivation(out_act), .dbg_state_o(dbg_state)
  );

  // clock / timeout
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=%0d cycles required=finish", cyc);
    $fatal(1, "timeout");
  end

  // reference model: floor-divide by 2^FRAC, add bias, clamp to [0, 2^(DW-1)-1]
  function automatic logic [DW-1:0] ref_act(input longint s, input int b);
    longint q, v, maxv, d;
    d    = longint'(1) << FRAC;
    maxv = (longint'(1) << (DW-1)) - 1;
    q = s / d;
    if (s < 0 && (s % d) != 0) q = q - 1;
    v = q + longint'(b);
    if (v < 0) v = 0;
    if (v > maxv) v = maxv;
    return v[DW-1:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic longint gen_sum();
    longint s;
    case ($urandom_range(0, 3))
      0: s = $signed({$urandom, $urandom}) >>> (64 - ACC);
      1: s = longint'($urandom_range(0, 32'h1200000)) - longint'(32'h900000);
      2: s = longint'($urandom_range(0, 32'h20000)) - longint'(32'h10000);
      default: s = longint'($urandom_range(0, 2048)) - 64'sd1024;
    endcase
    return s;
  endfunction

  function automatic int gen_bias();
    if ($urandom_range(0, 1) == 1) return int'($urandom_range(0, 65535)) - 32768;
    return int'($urandom_range(0, 1024)) - 512;
  endfunction

  task automatic apply_inputs();
    longint t;
    int     b;
    for (int i = 0; i < N; i++) begin
      t = vs[i];
      b = vb[i];
      sums_drv[i] = t[ACC-1:0];
      bias_drv[i] = b[DW-1:0];
    end
  endtask

  task automatic load_random();
    for (int i = 0; i < N; i++) begin
      vs[i] = gen_sum();
      vb[i] = gen_bias();
    end
    apply_inputs();
  endtask

  task automatic push_expected();
    logic [DW-1:0] e;
    for (int i = 0; i < N; i++) begin
      e = ref_act(vs[i], vb[i]);
      exp_q.push_back(e);
      last_exp[i] = e;
    end
  endtask

  task automatic accept_vector(input string tag);
    int n;
    n = 0;
    apply_inputs();
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    check({tag, "_accept_wait"}, 64'(n < 50), 64'd1);
    step();
    push_expected();
    in_valid = 1'b0;
    check({tag, "_busy"}, 64'(in_ready), 64'd0);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 200) begin
      step();
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(N));
  endtask

  // scoreboard: compare every entry against the queued expectation
  task automatic check_outputs(input string tag);
    logic [DW-1:0] e;
    for (int i = 0; i < N; i++) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $error("FAIL %s_sb_empty observed=0x%0h expected=queued_value", tag, out_act[i]);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("%s_act%0d", tag, i), 64'(out_act[i]), 64'(e));
      end
    end
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_ov_drop"}, 64'(out_valid), 64'd0);
    check({tag, "_ready_back"}, 64'(in_ready), 64'd1);
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < N; i++) check($sformatf("%s_zero%0d", tag, i), 64'(out_act[i]), 64'd0);
  endtask

  initial begin
    int  acc_cnt, pulses, last_pulse, n;
    logic acc, prev_ov;

    rst       = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    load_random();

    // reset held with in_valid high
    for (int k = 0; k < 3; k++) begin
      step();
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
    end
    check_all_zero("rst");
    rst      = 1'b1;
    in_valid = 1'b0;
    step();
    check("rel_in_ready", 64'(in_ready), 64'd1);

    // nominal plus truncation / saturation corners in the first entries
    load_random();
    vs[0] = 64'sh30000;    vb[0] = 32'h0100;
    vs[1] = -64'sh30000;   vb[1] = 32'h0100;
    vs[2] = 64'sh1FF;      vb[2] = 0;
    vs[3] = -64'sd1;       vb[3] = 0;
    vs[4] = 64'sh1000000;  vb[4] = 32'h0100;
    vs[5] = 64'sh7FFF00;   vb[5] = 1;
    vs[6] = 64'sh7FFE00;   vb[6] = 1;
    accept_vector("nom");
    wait_done("nom");
    check("nom_e0", 64'(out_act[0]), 64'h0400);
    check("nom_e1", 64'(out_act[1]), 64'h0000);
    check("nom_e2", 64'(out_act[2]), 64'h0001);
    check("trunc_neg1", 64'(out_act[3]), 64'h0000);
    check("sat_big", 64'(out_act[4]), 64'h7FFF);
    check("sat_edge", 64'(out_act[5]), 64'h7FFF);
    check("exact_max", 64'(out_act[6]), 64'h7FFF);
    check_outputs("nom");
    handshake("nom");

    // backpressure in DONE with noisy inputs
    load_random();
    accept_vector("bp");
    wait_done("bp");
    for (int k = 0; k < 5; k++) begin
      in_valid = ~in_valid;
      for (int i = 0; i < N; i++) begin
        sums_drv[i] = ACC'($urandom);
        bias_drv[i] = DW'($urandom);
      end
      step();
      check("bp_ov_hold", 64'(out_valid), 64'd1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      for (int i = 0; i < N; i++)
        check($sformatf("bp_stable%0d", i), 64'(out_act[i]), 64'(last_exp[i]));
    end
    in_valid = 1'b0;
    check_outputs("bp");
    handshake("bp");
    load_random();
    accept_vector("bp_next");
    wait_done("bp_next");
    check_outputs("bp_next");
    handshake("bp_next");

    // reset in the middle of PROC
    load_random();
    accept_vector("mid");
    exp_q.delete();
    step();
    step();
    rst = 1'b0;
    step();
    check_all_zero("mid");
    check("mid_ov", 64'(out_valid), 64'd0);
    check("mid_in_ready", 64'(in_ready), 64'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("mid_ov_hold", 64'(out_valid), 64'd0);
    end
    rst = 1'b1;
    step();
    check("mid_rel_ready", 64'(in_ready), 64'd1);
    load_random();
    accept_vector("mid_next");
    wait_done("mid_next");
    check_outputs("mid_next");
    handshake("mid_next");

    // back-to-back vectors with both sides always willing
    out_ready  = 1'b1;
    load_random();
    in_valid   = 1'b1;
    acc_cnt    = 0;
    pulses     = 0;
    last_pulse = 0;
    prev_ov    = 1'b0;
    n          = 0;
    while (pulses < 4 && n < 400) begin
      acc = in_valid && in_ready;
      step();
      n++;
      if (acc) begin
        push_expected();
        acc_cnt++;
        if (acc_cnt < 4) load_random();
        else in_valid = 1'b0;
      end
      if (out_valid) begin
        check("b2b_width", 64'(prev_ov), 64'd0);
        if (pulses > 0) check("b2b_spacing", 64'(cyc - last_pulse), 64'd32);
        last_pulse = cyc;
        pulses++;
        check_outputs($sformatf("b2b%0d", pulses));
      end
      prev_ov = out_valid;
    end
    check("b2b_count", 64'(pulses), 64'd4);
    step();
    check("b2b_final_drop", 64'(out_valid), 64'd0);
    out_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
